// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath driven by an external sequencer.
// Ports: Clk, Rst_n, Load/Ad/Sh controls, Mplier/Mcand operands -> M, K, Product.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Load,
    input  logic               Ad,
    input  logic               Sh,
    input  logic [WIDTH-1:0]   Mplier,
    input  logic [WIDTH-1:0]   Mcand,
    output logic               M,
    output logic               K,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_add;
    logic [2*WIDTH:0] w_pre;
    logic [CW-1:0]    w_cnt_nxt;

    // Upper half plus multiplicand; the extra bit lands in the carry
    // position so max*max never loses a bit.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mc};
    assign w_add = {w_sum, r_acc[WIDTH-1:0]};

    // Ad+Sh in one cycle shifts the freshly added value.
    assign w_pre = Ad ? w_add : r_acc;

    assign w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_acc <= '0;
            r_mc  <= '0;
            r_cnt <= '0;
        end else if (Load) begin
            r_acc <= {{(WIDTH + 1){1'b0}}, Mplier};
            r_mc  <= Mcand;
            r_cnt <= '0;
        end else if (Sh) begin
            r_acc <= {1'b0, w_pre[2*WIDTH:1]};
            r_cnt <= w_cnt_nxt;
        end else if (Ad) begin
            r_acc <= w_add;
        end
    end

    assign M       = r_acc[0];
    assign K       = (r_cnt == CNT_LAST);
    assign Product = r_acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath with an arithmetic reference model.
// Ports: none; drives the sequencer controls and checks M, K, Product.
module tb_mult_datapath;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b1;
    logic           Load = 1'b0;
    logic           Ad = 1'b0;
    logic           Sh = 1'b0;
    logic [W-1:0]   Mplier = '0;
    logic [W-1:0]   Mcand = '0;
    logic           M;
    logic           K;
    logic [2*W-1:0] Product;

    int checks = 0;
    int failures = 0;

    mult_datapath #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Mplier  (Mplier),
        .Mcand   (Mcand),
        .M       (M),
        .K       (K),
        .Product (Product)
    );

    always #5 Clk = ~Clk;

    // Reference model: accumulator as a plain integer, counter modulo W.
    localparam logic [63:0] LOM = (64'd1 << W) - 64'd1;
    localparam logic [63:0] PM  = (64'd1 << (2 * W)) - 64'd1;
    logic [63:0] macc = '0;
    logic [63:0] mmc = '0;
    int          mcnt = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            macc = '0;
            mmc  = '0;
            mcnt = 0;
        end else if (Load) begin
            macc = 64'(Mplier);
            mmc  = 64'(Mcand);
            mcnt = 0;
        end else begin
            if (Ad)
                macc = ((((macc >> W) & LOM) + mmc) << W) | (macc & LOM);
            if (Sh) begin
                macc = macc >> 1;
                mcnt = (mcnt + 1) % W;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge Clk) begin
        chk("cyc_M", 64'(M), macc & 64'd1);
        chk("cyc_K", 64'(K), 64'(mcnt == W - 1));
        chk("cyc_P", 64'(Product), macc & PM);
    end

    task automatic step(input logic l, input logic a, input logic s);
        @(posedge Clk);
        #2;
        Load = l;
        Ad   = a;
        Sh   = s;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0);
    endtask

    // Load then nsh rounds of add-check / shift; the last Sh is still
    // pending on return.
    task automatic run_mult(input logic [W-1:0] mp, input logic [W-1:0] mc,
                            input bit scr, input bit m0, input int nsh);
        Mplier = mp;
        Mcand  = mc;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < nsh; i++) begin
            @(posedge Clk);
            #2;
            if (scr) begin
                Mplier = '1;
                Mcand  = '1;
            end
            if (m0)
                chk("m_zero", 64'(M), 64'd0);
            Load = 1'b0;
            Ad   = macc[0];
            Sh   = 1'b0;
            @(posedge Clk);
            #2;
            chk("k_sh", 64'(K), 64'(i == W - 1));
            Ad = 1'b0;
            Sh = 1'b1;
        end
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        #1;
        chk("rst_P", 64'(Product), 64'd0);
        chk("rst_M", 64'(M), 64'd0);
        chk("rst_K", 64'(K), 64'd0);
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        idle();
        idle();
        chk("idle_P", 64'(Product), 64'd0);

        run_mult(8'd13, 8'd11, 1'b0, 1'b0, W);
        idle();
        chk("p13x11", 64'(Product), 64'd143);
        chk("mdl13x11", macc & PM, 64'd143);
        chk("k_after", 64'(K), 64'd0);

        run_mult(8'd255, 8'd255, 1'b0, 1'b0, W);
        idle();
        chk("p255x255", 64'(Product), 64'd65025);

        run_mult(8'd0, 8'd200, 1'b0, 1'b1, W);
        idle();
        chk("p0x200", 64'(Product), 64'd0);
        chk("k_wrap", 64'(K), 64'd0);

        run_mult(8'd6, 8'd7, 1'b1, 1'b0, W);
        idle();
        chk("p6x7scr", 64'(Product), 64'd42);

        run_mult(8'd9, 8'd9, 1'b0, 1'b0, 3);
        idle();
        #1 Rst_n = 1'b0;
        #1;
        chk("ab_P", 64'(Product), 64'd0);
        chk("ab_K", 64'(K), 64'd0);
        @(posedge Clk);
        #2 Rst_n = 1'b1;
        idle();
        chk("ab_hold", 64'(Product), 64'd0);
        run_mult(8'd9, 8'd9, 1'b0, 1'b0, W);
        idle();
        chk("p9x9", 64'(Product), 64'd81);

        Mplier = 8'd5;
        Mcand  = 8'd3;
        step(1'b1, 1'b1, 1'b1);
        idle();
        chk("ld_pri_P", 64'(Product), 64'd5);
        chk("ld_pri_K", 64'(K), 64'd0);
        step(1'b0, 1'b1, 1'b1);
        idle();
        chk("adsh", 64'(Product), 64'd386);

        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle();
        chk("ad_then_sh", 64'(Product), 64'd386);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
